// File: rtl/cam_match_scan.sv
// cam_match_scan: walks a captured 16-bit CAM match vector and emits one
// result per output handshake, lowest hit index first. A search with no hits
// produces a single miss result. The busy output reflects the FSM state
// (IDLE/SCAN) for observation.
// Optional feature macro: CAM_SCAN_HITCNT_EN adds the hit_cnt output
// (popcount of the accepted match vector).
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. Valid is never withdrawn by this block while
// a result waits, and result fields stay stable until the transfer. in_ready
// is combinational from out_ready and flush so a finishing scan can take the
// next request in the same cycle.
module cam_match_scan #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_match,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_idx,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last,
  output logic             out_miss,
  output logic             busy
`ifdef CAM_SCAN_HITCNT_EN
  ,
  output logic [4:0]       hit_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0]      pend_q, pend_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       lsb_idx;
  logic             scan;
  logic             at_most_one;
  logic             take;
  logic             accept;

  // Priority encode the lowest pending hit; 0 when nothing is pending.
  always_comb begin
    lsb_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) lsb_idx = 4'(i);
    end
  end

  assign scan        = (state_q == SCAN);
  assign at_most_one = ((pend_q & (pend_q - 16'd1)) == 16'd0);

  assign out_valid = scan;
  assign busy      = scan;
  assign out_idx   = scan ? lsb_idx : 4'd0;
  assign out_last  = scan && at_most_one;
  assign out_miss  = scan && (pend_q == 16'd0);
  assign out_tag   = tag_q;

  assign take     = out_valid && out_ready;
  assign in_ready = !flush && (!scan || (take && out_last));
  assign accept   = in_valid && in_ready;

  // Next state: flush dominates, then a new accept, then retiring one hit.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    tag_d   = tag_q;
    if (flush) begin
      state_d = IDLE;
      pend_d  = 16'd0;
    end else if (accept) begin
      state_d = SCAN;
      pend_d  = in_match;
      tag_d   = in_tag;
    end else if (take) begin
      // Clearing bit 0 of an empty vector on a miss result is harmless.
      pend_d = pend_q & ~(16'd1 << lsb_idx);
      if (out_last) state_d = IDLE;
    end
  end

  // State, pending hits and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 16'd0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
    end
  end

`ifdef CAM_SCAN_HITCNT_EN
  logic [4:0] pop_cnt;
  logic [4:0] hit_cnt_q, hit_cnt_d;

  // Population count of the offered match vector.
  always_comb begin
    pop_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop_cnt = pop_cnt + 5'(in_match[i]);
    end
  end

  // Hit count is captured on accept and held for the whole scan.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (flush)       hit_cnt_d = 5'd0;
    else if (accept) hit_cnt_d = pop_cnt;
  end

  // Hit count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_q <= 5'd0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_cam_match_scan.sv
// Testbench for cam_match_scan: directed scenarios plus randomized traffic
// checked against a queue-based model of the expected result stream.
// Build with +define+CAM_SCAN_HITCNT_EN to also check hit_cnt.
module tb_cam_match_scan;

  localparam int TAG_W = 4;
  localparam int RW    = TAG_W + 6;  // {tag, idx, last, miss}

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_match;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_idx;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;
  logic             out_miss;
  logic             busy;
`ifdef CAM_SCAN_HITCNT_EN
  logic [4:0]       hit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cam_match_scan #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_match  (in_match),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .out_miss  (out_miss),
    .busy      (busy)
`ifdef CAM_SCAN_HITCNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  // exp_q holds the results still owed for the current search, in order.
  logic [RW-1:0] exp_q[$];
  logic [RW:0]   exp_log[$];
  logic [RW:0]   obs_log[$];
  int            rdy_mis = 0;
  int            vld_mis = 0;
  logic          m_valid;
  logic          m_ready;
  int            m_hi;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      m_valid = (exp_q.size() != 0);
      m_ready = !flush && (!m_valid || (out_ready && exp_q[0][1]));
      if (out_valid !== m_valid) vld_mis++;
      if (in_ready !== m_ready) rdy_mis++;
      if (out_valid && out_ready) begin
        obs_log.push_back({1'b0, out_tag, out_idx, out_last, out_miss});
        if (m_valid) exp_log.push_back({1'b0, exp_q.pop_front()});
        else         exp_log.push_back({1'b1, {RW{1'b0}}});
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && m_ready) begin
        m_hi = -1;
        for (int i = 0; i < 16; i++) if (in_match[i]) m_hi = i;
        for (int i = 0; i < 16; i++) begin
          if (in_match[i]) exp_q.push_back({in_tag, 4'(i), (i == m_hi), 1'b0});
        end
        if (m_hi < 0) exp_q.push_back({in_tag, 4'd0, 1'b1, 1'b1});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", out_last); end
    checks++; if (out_miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %0b want 0", out_miss); end
    checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
`ifdef CAM_SCAN_HITCNT_EN
    checks++; if (hit_cnt !== 5'd0) begin errors++; $display("FAIL reset_hit_cnt got %0d want 0", hit_cnt); end
`endif
  endtask

  task automatic test_hits_8421();
    int exp_idx[4] = '{0, 5, 10, 15};
    out_ready = 1'b1; in_valid = 1'b1; in_match = 16'h8421; in_tag = 4'd3;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL h8421_valid[%0d] got %0b want 1", k, out_valid); end
      checks++; if (out_idx !== 4'(exp_idx[k])) begin errors++; $display("FAIL h8421_idx[%0d] got %0d want %0d", k, out_idx, exp_idx[k]); end
      checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL h8421_last[%0d] got %0b want %0b", k, out_last, (k == 3)); end
      checks++; if (out_tag !== 4'd3) begin errors++; $display("FAIL h8421_tag[%0d] got %0d want 3", k, out_tag); end
`ifdef CAM_SCAN_HITCNT_EN
      checks++; if (hit_cnt !== 5'd4) begin errors++; $display("FAIL h8421_hit_cnt[%0d] got %0d want 4", k, hit_cnt); end
`endif
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL h8421_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_miss();
    out_ready = 1'b1; in_valid = 1'b1; in_match = 16'h0000; in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL miss_valid got %0b want 1", out_valid); end
    checks++; if (out_miss !== 1'b1) begin errors++; $display("FAIL miss_miss got %0b want 1", out_miss); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL miss_last got %0b want 1", out_last); end
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL miss_idx got %0d want 0", out_idx); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL miss_idle got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL miss_busy got %0b want 0", busy); end
  endtask

  task automatic test_stall_ffff();
    out_ready = 1'b0; in_valid = 1'b1; in_match = 16'hFFFF; in_tag = 4'd7;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_last !== 1'b0 || out_tag !== 4'd7)
        begin errors++; $display("FAIL stall_hold[%0d] got v%0b i%0d l%0b t%0d want v1 i0 l0 t7", k, out_valid, out_idx, out_last, out_tag); end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_last !== (k == 15))
        begin errors++; $display("FAIL ffff_seq[%0d] got v%0b i%0d l%0b want v1 i%0d l%0b", k, out_valid, out_idx, out_last, k, (k == 15)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ffff_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_match = 16'h0002; in_tag = 4'd1;
    tick();
    in_match = 16'h0100; in_tag = 4'd2;
    checks++; if (out_idx !== 4'd1 || out_last !== 1'b1 || out_tag !== 4'd1)
      begin errors++; $display("FAIL b2b_a got i%0d l%0b t%0d want i1 l1 t1", out_idx, out_last, out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd8 || out_last !== 1'b1 || out_tag !== 4'd2)
      begin errors++; $display("FAIL b2b_b got v%0b i%0d l%0b t%0d want v1 i8 l1 t2", out_valid, out_idx, out_last, out_tag); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_match = 16'h00F0; in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    checks++; if (out_idx !== 4'd4) begin errors++; $display("FAIL flush_first got %0d want 4", out_idx); end
    tick();
    checks++; if (out_idx !== 4'd5) begin errors++; $display("FAIL flush_second got %0d want 5", out_idx); end
    flush = 1'b1; in_valid = 1'b1; in_match = 16'h0003;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet[%0d] got v%0b i%0d want v0", k, out_valid, out_idx); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_match = 16'h0C00; in_tag = 4'd12;
    tick();
    in_valid = 1'b0;
    checks++; if (out_idx !== 4'd10 || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got v%0b i%0d want v1 i10", out_valid, out_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 4'd0 || out_last !== 1'b0 || out_miss !== 1'b0 || out_tag !== 4'd0)
      begin errors++; $display("FAIL rmid_async got v%0b b%0b i%0d l%0b m%0b t%0d want all 0", out_valid, busy, out_idx, out_last, out_miss, out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %0b want 1", in_ready); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_match = 16'h0001; in_tag = 4'd5;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_last !== 1'b1 || out_tag !== 4'd5)
      begin errors++; $display("FAIL rmid_next got v%0b i%0d l%0b t%0d want v1 i0 l1 t5", out_valid, out_idx, out_last, out_tag); end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale[%0d] got v%0b i%0d want v0", k, out_valid, out_idx); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(1, 0) == 1);
      out_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(24, 0) == 0);
      in_tag    = TAG_W'($urandom);
      case ($urandom_range(3, 0))
        0:       in_match = 16'h0000;
        1:       in_match = 16'h0001 << $urandom_range(15, 0);
        2:       in_match = 16'($urandom);
        default: in_match = 16'($urandom) & 16'($urandom);
      endcase
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && out_valid; c++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL random_drain_timeout got v%0b want 0", out_valid); end
    tick();
  endtask

  task automatic test_scoreboard();
    checks++; if (obs_log.size() < 50) begin errors++; $display("FAIL sb_result_count got %0d want >=50", obs_log.size()); end
    for (int i = 0; i < obs_log.size(); i++) begin
      checks++;
      if (obs_log[i] !== exp_log[i]) begin
        errors++;
        $display("FAIL sb_result[%0d] got %h want %h", i, obs_log[i], exp_log[i]);
      end
    end
    checks++; if (rdy_mis !== 0) begin errors++; $display("FAIL sb_in_ready got %0d mismatching cycles want 0", rdy_mis); end
    checks++; if (vld_mis !== 0) begin errors++; $display("FAIL sb_out_valid got %0d mismatching cycles want 0", vld_mis); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_outstanding got %0d want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_match = 16'h0;
    in_tag = '0; out_ready = 1'b0;
    #3;
    test_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    test_hits_8421();
    test_miss();
    test_stall_ffff();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
